// File: rtl/tlm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlm_pkg
// Purpose  : Shared defaults, bank-state encoding and drop-counter width for
//            the TLM result collector and its bank storage.
// Contents : NUM_DEF, ITEM_WIDTH_DEF, DROP_CNT_W, bank_state_e
// Revision : 1.0 - initial release
// ============================================================================
package tlm_pkg;

  localparam int NUM_DEF        = 50;
  localparam int ITEM_WIDTH_DEF = 8;
  localparam int DROP_CNT_W     = 16;

  // Lifecycle of one ping-pong bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage : tlm_pkg
`default_nettype wire

// File: rtl/tlm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tlm_bank
// Purpose  : One storage bank of NUM items with an indexed write port, a
//            synchronous clear and a packed read-out.
// Ports    : clk_i      - clock
//            reset_ni   - asynchronous active-low reset
//            wr_en_i    - write wr_data_i into slot wr_idx_i
//            wr_idx_i   - slot index
//            wr_data_i  - item to store
//            clr_i      - zero the whole bank (wins over a write)
//            data_o     - packed contents, slot k at [k*ITEM_WIDTH +: ITEM_WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module tlm_bank
  import tlm_pkg::*;
#(
  parameter int NUM        = NUM_DEF,
  parameter int ITEM_WIDTH = ITEM_WIDTH_DEF,
  parameter int IDX_W      = $clog2(NUM + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      wr_en_i,
  input  logic [IDX_W-1:0]          wr_idx_i,
  input  logic [ITEM_WIDTH-1:0]     wr_data_i,
  input  logic                      clr_i,
  output logic [NUM*ITEM_WIDTH-1:0] data_o
);

  logic [NUM*ITEM_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < NUM; k++) begin
        if (wr_idx_i == IDX_W'(k)) begin
          data_q[k*ITEM_WIDTH +: ITEM_WIDTH] <= wr_data_i;
        end
      end
    end
  end

  assign data_o = data_q;

endmodule : tlm_bank
`default_nettype wire

// File: rtl/tlm_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tlm_result_collector
// Purpose  : Collects a stream of result items into two ping-pong banks of NUM
//            items and presents each completed bank as one packed payload.
//            Items arriving while the write bank is still full are dropped and
//            counted.
// Ports    : clk_i           - clock
//            reset_ni        - asynchronous active-low reset
//            res_i           - result item
//            res_valid_i     - res_i valid this cycle
//            flush_i         - close the partially filled write bank
//            payload_o       - packed contents of the read bank
//            payload_valid_o - read bank is complete
//            payload_count_o - valid items in payload_o
//            payload_ack_i   - reader consumed payload_o
//            overflow_o      - sticky: an item was dropped
//            drop_cnt_o      - saturating count of dropped items
// Revision : 1.0 - initial release
// ============================================================================
module tlm_result_collector
  import tlm_pkg::*;
#(
  parameter int NUM        = NUM_DEF,
  parameter int ITEM_WIDTH = ITEM_WIDTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [ITEM_WIDTH-1:0]       res_i,
  input  logic                        res_valid_i,
  input  logic                        flush_i,
  output logic [NUM*ITEM_WIDTH-1:0]   payload_o,
  output logic                        payload_valid_o,
  output logic [$clog2(NUM+1)-1:0]    payload_count_o,
  input  logic                        payload_ack_i,
  output logic                        overflow_o,
  output logic [DROP_CNT_W-1:0]       drop_cnt_o
);

  localparam int CNT_W = $clog2(NUM + 1);
  localparam int PW    = NUM * ITEM_WIDTH;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  bank_state_e           state_q [2];
  bank_state_e           state_d [2];
  logic [CNT_W-1:0]      cnt_q   [2];
  logic [CNT_W-1:0]      cnt_d   [2];
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // --------------------------------------------------------------------------
  // Event decode (all from registered state, so an ack freeing the write bank
  // this cycle cannot rescue an item arriving this same cycle)
  // --------------------------------------------------------------------------
  logic             wr_full_w;
  logic             accept_w;
  logic             drop_w;
  logic             last_w;
  logic             close_w;
  logic [CNT_W-1:0] close_cnt_w;
  logic             ack_w;

  assign wr_full_w   = (state_q[wr_bank_q] == FULL);
  assign accept_w    = res_valid_i && !wr_full_w;
  assign drop_w      = res_valid_i && wr_full_w;
  assign last_w      = accept_w && (idx_q == CNT_W'(NUM - 1));
  // A flush counts an item stored on the same edge; the natural full
  // transition already covers the last slot, so flush adds nothing there.
  assign close_w     = last_w || (flush_i && ((idx_q != '0) || accept_w));
  assign close_cnt_w = idx_q + CNT_W'(accept_w);
  assign ack_w       = payload_ack_i && (state_q[rd_bank_q] == FULL);

  // --------------------------------------------------------------------------
  // Next-state logic. An ack always targets a full bank and a close always
  // targets a non-full bank, so the two never touch the same bank.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (ack_w) begin
      state_d[rd_bank_q] = EMPTY;
      cnt_d[rd_bank_q]   = '0;
      rd_bank_d          = ~rd_bank_q;
    end

    if (close_w) begin
      state_d[wr_bank_q] = FULL;
      cnt_d[wr_bank_q]   = close_cnt_w;
      idx_d              = '0;
      wr_bank_d          = ~wr_bank_q;
    end else if (accept_w) begin
      state_d[wr_bank_q] = FILLING;
      idx_d              = idx_q + CNT_W'(1);
    end

    if (drop_w) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      idx_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      idx_q      <= idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bank storage
  // --------------------------------------------------------------------------
  logic [PW-1:0] bank_data_w [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tlm_bank #(
      .NUM        (NUM),
      .ITEM_WIDTH (ITEM_WIDTH),
      .IDX_W      (CNT_W)
    ) u_bank (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .wr_en_i   (accept_w && (wr_bank_q == 1'(b))),
      .wr_idx_i  (idx_q),
      .wr_data_i (res_i),
      .clr_i     (ack_w && (rd_bank_q == 1'(b))),
      .data_o    (bank_data_w[b])
    );
  end : g_bank

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign payload_o       = bank_data_w[rd_bank_q];
  assign payload_valid_o = (state_q[rd_bank_q] == FULL);
  assign payload_count_o = cnt_q[rd_bank_q];
  assign overflow_o      = overflow_q;
  assign drop_cnt_o      = drop_cnt_q;

endmodule : tlm_result_collector
`default_nettype wire

// File: tb/tb_tlm_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlm_result_collector
// Purpose  : Directed, table-driven bench for tlm_result_collector at NUM=4,
//            ITEM_WIDTH=8, plus a hand-written reset-mid-fill sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlm_result_collector;

  localparam int NUM = 4;
  localparam int IW  = 8;
  localparam int CW  = $clog2(NUM + 1);

  logic              clk;
  logic              reset_ni;
  logic [IW-1:0]     res;
  logic              res_valid;
  logic              flush;
  logic [NUM*IW-1:0] payload;
  logic              payload_valid;
  logic [CW-1:0]     payload_count;
  logic              payload_ack;
  logic              overflow;
  logic [15:0]       drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  tlm_result_collector #(
    .NUM        (NUM),
    .ITEM_WIDTH (IW)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_ni),
    .res_i           (res),
    .res_valid_i     (res_valid),
    .flush_i         (flush),
    .payload_o       (payload),
    .payload_valid_o (payload_valid),
    .payload_count_o (payload_count),
    .payload_ack_i   (payload_ack),
    .overflow_o      (overflow),
    .drop_cnt_o      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  res;
    logic        v;
    logic        fl;
    logic        ack;
    logic        ev;
    logic [31:0] ep;
    logic [2:0]  ec;
    logic        eo;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] r, input logic v, input logic fl, input logic ak,
                     input logic ev, input logic [31:0] ep, input logic [2:0] ec,
                     input logic eo, input logic [15:0] ed);
    vec_t t;
    t.res = r; t.v = v; t.fl = fl; t.ack = ak;
    t.ev = ev; t.ep = ep; t.ec = ec; t.eo = eo; t.ed = ed;
    tbl.push_back(t);
  endtask

  task automatic check(input string nm, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic ev, input logic [31:0] ep,
                           input logic [2:0] ec, input logic eo, input logic [15:0] ed);
    check("payload_valid", row, 64'(payload_valid), 64'(ev));
    check("payload",       row, 64'(payload),       64'(ep));
    check("payload_count", row, 64'(payload_count), 64'(ec));
    check("overflow",      row, 64'(overflow),      64'(eo));
    check("drop_cnt",      row, 64'(drop_cnt),      64'(ed));
  endtask

  task automatic drive(input logic [7:0] r, input logic v, input logic fl, input logic ak);
    @(negedge clk);
    res = r; res_valid = v; flush = fl; payload_ack = ak;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_ni = 1'b0; res = '0; res_valid = 1'b0; flush = 1'b0; payload_ack = 1'b0;

    // Basic fill of bank 0, then release it
    add(8'h01,1,0,0, 0,32'h00000001,0,0,0);
    add(8'h02,1,0,0, 0,32'h00000201,0,0,0);
    add(8'h03,1,0,0, 0,32'h00030201,0,0,0);
    add(8'h04,1,0,0, 1,32'h04030201,4,0,0);
    add(8'h00,0,0,1, 0,32'h00000000,0,0,0);
    // Both banks full without ack, then drain in order
    add(8'h10,1,0,0, 0,32'h00000010,0,0,0);
    add(8'h11,1,0,0, 0,32'h00001110,0,0,0);
    add(8'h12,1,0,0, 0,32'h00121110,0,0,0);
    add(8'h13,1,0,0, 1,32'h13121110,4,0,0);
    add(8'h14,1,0,0, 1,32'h13121110,4,0,0);
    add(8'h15,1,0,0, 1,32'h13121110,4,0,0);
    add(8'h16,1,0,0, 1,32'h13121110,4,0,0);
    add(8'h17,1,0,0, 1,32'h13121110,4,0,0);
    add(8'h00,0,0,1, 1,32'h17161514,4,0,0);
    add(8'h00,0,0,1, 0,32'h00000000,0,0,0);
    // Overflow: 12 items, last 4 dropped
    add(8'h01,1,0,0, 0,32'h00000001,0,0,0);
    add(8'h02,1,0,0, 0,32'h00000201,0,0,0);
    add(8'h03,1,0,0, 0,32'h00030201,0,0,0);
    add(8'h04,1,0,0, 1,32'h04030201,4,0,0);
    add(8'h05,1,0,0, 1,32'h04030201,4,0,0);
    add(8'h06,1,0,0, 1,32'h04030201,4,0,0);
    add(8'h07,1,0,0, 1,32'h04030201,4,0,0);
    add(8'h08,1,0,0, 1,32'h04030201,4,0,0);
    add(8'h09,1,0,0, 1,32'h04030201,4,1,1);
    add(8'h0A,1,0,0, 1,32'h04030201,4,1,2);
    add(8'h0B,1,0,0, 1,32'h04030201,4,1,3);
    add(8'h0C,1,0,0, 1,32'h04030201,4,1,4);
    // Item while write bank full, ack frees it same cycle: still dropped
    add(8'h0D,1,0,1, 1,32'h08070605,4,1,5);
    add(8'h00,0,0,1, 0,32'h00000000,0,1,5);
    // Flush of a partial bank, then flush with nothing pending
    add(8'hAA,1,0,0, 0,32'h000000AA,0,1,5);
    add(8'hBB,1,0,0, 0,32'h0000BBAA,0,1,5);
    add(8'h00,0,1,0, 1,32'h0000BBAA,2,1,5);
    add(8'h00,0,1,0, 1,32'h0000BBAA,2,1,5);
    add(8'h00,0,0,1, 0,32'h00000000,0,1,5);
    // Ack while nothing valid is ignored
    add(8'h21,1,0,1, 0,32'h00000021,0,1,5);
    add(8'h22,1,0,0, 0,32'h00002221,0,1,5);
    add(8'h23,1,0,0, 0,32'h00232221,0,1,5);
    add(8'h24,1,0,0, 1,32'h24232221,4,1,5);
    // Ack one bank while the other completes
    add(8'h31,1,0,0, 1,32'h24232221,4,1,5);
    add(8'h32,1,0,0, 1,32'h24232221,4,1,5);
    add(8'h33,1,0,0, 1,32'h24232221,4,1,5);
    add(8'h34,1,0,1, 1,32'h34333231,4,1,5);
    add(8'h00,0,0,1, 0,32'h00000000,0,1,5);
    // Flush together with the last item: single close only
    add(8'h41,1,0,0, 0,32'h00000041,0,1,5);
    add(8'h42,1,0,0, 0,32'h00004241,0,1,5);
    add(8'h43,1,0,0, 0,32'h00434241,0,1,5);
    add(8'h44,1,1,0, 1,32'h44434241,4,1,5);
    add(8'h00,0,0,1, 0,32'h00000000,0,1,5);
    // Flush together with a mid-bank item: item included in the count
    add(8'h51,1,0,0, 0,32'h00000051,0,1,5);
    add(8'h52,1,1,0, 1,32'h00005251,2,1,5);
    add(8'h00,0,0,1, 0,32'h00000000,0,1,5);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    reset_ni = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].res, tbl[i].v, tbl[i].fl, tbl[i].ack);
      check_all(i, tbl[i].ev, tbl[i].ep, tbl[i].ec, tbl[i].eo, tbl[i].ed);
    end

    // Reset mid-fill: partial data and sticky flags are discarded
    drive(8'h61, 1, 0, 0);
    drive(8'h62, 1, 0, 0);
    drive(8'h63, 1, 0, 0);
    check_all(100, 0, 32'h00636261, 0, 1, 5);
    @(negedge clk);
    reset_ni = 1'b0;
    res = 8'h65; res_valid = 1'b1; flush = 1'b0; payload_ack = 1'b0;
    #1;
    check_all(101, 0, 32'h0, 0, 0, 0);   // asynchronous clear
    @(posedge clk);
    #1;
    check_all(102, 0, 32'h0, 0, 0, 0);   // no item taken while in reset
    @(negedge clk);
    reset_ni = 1'b1;
    res_valid = 1'b0;
    drive(8'h71, 1, 0, 0);
    check_all(103, 0, 32'h00000071, 0, 0, 0);
    drive(8'h72, 1, 0, 0);
    drive(8'h73, 1, 0, 0);
    drive(8'h74, 1, 0, 0);
    check_all(104, 1, 32'h74737271, 4, 0, 0);
    drive(8'h00, 0, 0, 1);
    check_all(105, 0, 32'h0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tlm_result_collector
`default_nettype wire

// File: doc/tlm_result_collector.md
TLM_RESULT_COLLECTOR -- requirements
Module: tlm_result_collector

Interface
REQ-001 SHALL have parameter NUM, default 50, meaning items per payload.
REQ-002 SHALL have parameter ITEM_WIDTH, default 8, meaning bits per item.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port res_i  input  ITEM_WIDTH  result item from DUT (e.g. bfm res_o).
REQ-006 SHALL have port res_valid_i  input  1  res_i holds a valid item this cycle.
REQ-007 SHALL have port flush_i  input  1  close the partially filled bank early.
REQ-008 SHALL have port payload_o  output  NUM*ITEM_WIDTH  packed payload; item k at bits [k*ITEM_WIDTH +: ITEM_WIDTH].
REQ-009 SHALL have port payload_valid_o  output  1  payload_o holds a completed bank.
REQ-010 SHALL have port payload_count_o  output  $clog2(NUM+1)  number of valid items in payload_o.
REQ-011 SHALL have port payload_ack_i  input  1  reader (DPI side) has consumed payload_o.
REQ-012 SHALL have port overflow_o  output  1  sticky; an item was dropped.
REQ-013 SHALL have port drop_cnt_o  output  16  count of dropped items, saturating at 16'hFFFF.

Function
REQ-014 SHALL hold two banks of NUM items (ping-pong): write bank wr_bank, read bank rd_bank, per-bank full flag and item count, write index idx.
REQ-015 Per-bank states SHALL be EMPTY -> FILLING (first item written) -> FULL (NUM items or flush) -> EMPTY (ack).
REQ-016 res_valid_i=1 with wr_bank not FULL SHALL store res_i at slot idx of wr_bank and increment idx.
REQ-017 Accepting the item at idx=NUM-1 SHALL mark the bank FULL with count NUM, reset idx to 0 and toggle wr_bank at the same edge.
REQ-018 res_valid_i=1 with wr_bank FULL SHALL drop the item, set overflow_o, and increment drop_cnt_o.
REQ-019 payload_valid_o SHALL equal full[rd_bank]; payload_o and payload_count_o SHALL show rd_bank contents; latency from the accepting edge of the last item to payload_valid_o=1 is one edge, with no extra cycle.
REQ-020 payload_ack_i=1 while payload_valid_o=1 SHALL clear that bank to zero, mark it EMPTY and toggle rd_bank; ack while payload_valid_o=0 SHALL be ignored.
REQ-021 payload_o SHALL stay stable while payload_valid_o=1 and no ack is given.
REQ-022 flush_i=1 with idx>0 SHALL mark wr_bank FULL with count idx, reset idx and toggle wr_bank; unwritten slots read zero. flush_i with idx=0 SHALL have no effect.
REQ-023 flush_i and res_valid_i in the same cycle: the item SHALL be stored first and included in the flushed count. At idx=NUM-1, only the full transition occurs (no double close).
REQ-024 Ack of one bank and completion of the other bank in the same cycle SHALL both take effect.
REQ-025 An item arriving while wr_bank is FULL SHALL be dropped even if an ack frees that bank in the same cycle; full flags are registered.
REQ-026 overflow_o SHALL clear only on reset.

Reset
REQ-027 reset_ni=0 SHALL asynchronously clear both banks, full flags, counts, idx, wr_bank=rd_bank=0, payload_valid_o=0, payload_o=0, payload_count_o=0, overflow_o=0, drop_cnt_o=0.
REQ-028 Reset mid-fill or mid-read SHALL discard all partial and full data; no item SHALL be accepted on the edge where reset_ni is low.

Structure
REQ-029 Package tlm_pkg SHALL hold the NUM and ITEM_WIDTH defaults, the bank-state enum (EMPTY/FILLING/FULL), and DROP_CNT_W=16.
REQ-030 Sub-module tlm_bank SHALL implement one bank: storage, write port (index, data, enable), synchronous clear, and packed read-out. It is instantiated twice.

Verification (NUM=4, ITEM_WIDTH=8)
REQ-031 Feed 01,02,03,04 on consecutive cycles -> payload_valid_o=1 one edge after 04, payload_o=32'h04030201, count=4.
REQ-032 Feed 8 items 10..17 without ack -> both banks full; ack twice -> payloads 32'h13121110 then 32'h17161514, in order.
REQ-033 Feed 12 items with no ack -> items 9..12 dropped, overflow_o=1, drop_cnt_o=4, banks hold items 1..8.
REQ-034 Feed AA,BB then flush_i -> payload_o=32'h0000BBAA, count=2; flush_i with idx=0 -> no change.
REQ-035 Feed 3 items, then assert reset_ni low for one cycle -> all outputs 0; next 4 items form a fresh payload in bank 0.
REQ-036 Ack while payload_valid_o=0, and ack in the same cycle the other bank completes -> no state change for the first; for the second, rd_bank toggles and the new bank is valid on the next edge.
